imem_port_arbiter: RTL

- Shares one single-port, synchronous-read instruction memory between two requesters: the CPU fetch stage (read-only) and the program loader (write-only).
- Sequences a boot phase in which only the loader may write. It then runs round-robin arbitration.
- Converts byte addresses to word addresses and returns fetch data with fixed one-cycle latency.
- Sits between the fetch stage / loader and the instruction-memory array.

---
 rtl/imem_port_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/imem_port_arbiter.sv
// Arbitrates a single-port synchronous-read instruction memory between the fetch
// stage and the program loader. Only the loader may access it during boot.
module imem_port_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [DATA_W-1:0] fetch_rdata,
  output logic              fetch_err,
  input  logic              load_req,
  input  logic [31:0]       load_addr,
  input  logic [DATA_W-1:0] load_wdata,
  output logic              load_gnt,
  input  logic              load_done,
  output logic              booting,
  output logic [ADDR_W:0]   words_loaded,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {S_BOOT, S_RUN} state_e;
  typedef enum logic {LAST_LOAD, LAST_FETCH} last_e;

  localparam logic [ADDR_W:0] WL_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  last_e             last_q, last_d;
  logic              rvalid_q, err_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W:0]   wl_q, wl_d;
  logic              fetch_bad, load_bad;

  assign fetch_bad = (fetch_addr[1:0] != 2'b00) || (fetch_addr[31:ADDR_W+2] != '0);
  assign load_bad  = (load_addr[1:0] != 2'b00) || (load_addr[31:ADDR_W+2] != '0);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    wl_d      = wl_q;
    fetch_gnt = 1'b0;
    load_gnt  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = fetch_addr[ADDR_W+1:2];
    mem_wdata = load_wdata;

    if (state_q == S_BOOT && load_done) state_d = S_RUN;

    // Under contention the requester that did not win last time takes the port.
    if (state_q == S_RUN && fetch_req && load_req) begin
      if (last_q == LAST_LOAD) fetch_gnt = 1'b1;
      else                     load_gnt  = 1'b1;
    end else if (state_q == S_RUN && fetch_req) begin
      fetch_gnt = 1'b1;
    end else if (load_req) begin
      load_gnt = 1'b1;
    end

    if (fetch_gnt) begin
      last_d = LAST_FETCH;
      mem_en = !fetch_bad;
    end
    if (load_gnt) begin
      last_d   = LAST_LOAD;
      mem_en   = !load_bad;
      mem_we   = !load_bad;
      mem_addr = load_addr[ADDR_W+1:2];
      if (!load_bad && wl_q != WL_MAX) wl_d = wl_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_BOOT;
      last_q   <= LAST_LOAD;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      wl_q     <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      rvalid_q <= fetch_gnt;
      err_q    <= fetch_gnt && fetch_bad;
      wl_q     <= wl_d;
      if (rvalid_q) rdata_q <= fetch_rdata;
    end
  end

  // Memory data arrives in the rvalid cycle, so it is forwarded directly and
  // held afterwards.
  assign fetch_rdata  = rvalid_q ? (err_q ? '0 : mem_rdata) : rdata_q;
  assign fetch_rvalid = rvalid_q;
  assign fetch_err    = err_q;
  assign booting      = (state_q == S_BOOT);
  assign words_loaded = wl_q;

endmodule
